stock_buy_datapath: RTL and testbench

Sequential buy-side order processor for the market simulation: the counterpart of the sell path. It accepts one buy order per handshake and computes the cost as quantity × price with an 8-step shift-add multiplier. It checks the cost against available cash and the resulting holding against a quantity ceiling, then returns the updated holding and cash with an accept/reject code. One instance serves one stock; the market controller instantiates one per stock, alongside the sell datapath.

---
 rtl/stock_buy_datapath_pkg.sv | 23 ++
 rtl/stock_buy_datapath_if.sv | 25 ++
 rtl/stock_buy_datapath_seq_mult_8x12.sv | 50 +++++
 rtl/stock_buy_datapath.sv | 101 ++++++++++
 tb/tb_stock_buy_datapath.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/stock_buy_datapath_pkg.sv
// Shared market definitions: widths, FSM encoding and reject codes used by the
// buy and sell datapaths.
package market_pkg;
  localparam int QTY_W   = 8;
  localparam int PRICE_W = 12;
  localparam int CASH_W  = 24;
  localparam int COST_W  = 20;
  localparam int QTY_MAX = 255;
  localparam int MULT_STEPS = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_MULT  = 2'd1,
    ST_CHECK = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    REJ_OK   = 2'b00,
    REJ_CASH = 2'b01,
    REJ_QTY  = 2'b10
  } rej_e;
endpackage

// File: rtl/stock_buy_datapath_if.sv
// Order/result bus between the market controller and one buy datapath.
interface stock_buy_if;
  import market_pkg::*;
  logic               enable;
  logic               req_valid;
  logic               req_ready;
  logic [QTY_W-1:0]   buy_amt;
  logic [PRICE_W-1:0] stock_price;
  logic [QTY_W-1:0]   qty_init;
  logic [CASH_W-1:0]  cash_init;
  logic               done;
  logic [1:0]         reject_code;
  logic [QTY_W-1:0]   qty_out;
  logic [CASH_W-1:0]  cash_out;
  logic               busy;

  modport master (
    output enable, req_valid, buy_amt, stock_price, qty_init, cash_init,
    input  req_ready, done, reject_code, qty_out, cash_out, busy
  );
  modport slave (
    input  enable, req_valid, buy_amt, stock_price, qty_init, cash_init,
    output req_ready, done, reject_code, qty_out, cash_out, busy
  );
endinterface

// File: rtl/stock_buy_datapath_seq_mult_8x12.sv
// 8x12 shift-add multiplier, one multiplier bit per enabled cycle, LSB first.
module seq_mult_8x12
  import market_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               i_en,
  input  logic               i_start,
  input  logic [QTY_W-1:0]   i_a,
  input  logic [PRICE_W-1:0] i_b,
  output logic               o_busy,
  output logic               o_last,
  output logic [COST_W-1:0]  o_product
);
  logic [QTY_W-1:0]   r_a;
  logic [PRICE_W-1:0] r_b;
  logic [COST_W-1:0]  r_acc;
  logic [2:0]         r_step;
  logic               r_busy;
  logic [COST_W-1:0]  w_b_ext;
  logic [COST_W-1:0]  w_addend;

  assign w_b_ext   = COST_W'(r_b);
  assign w_addend  = w_b_ext << r_step;
  assign o_busy    = r_busy;
  assign o_last    = (r_step == 3'(MULT_STEPS - 1));
  assign o_product = r_acc;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a    <= '0;
      r_b    <= '0;
      r_acc  <= '0;
      r_step <= '0;
      r_busy <= 1'b0;
    end else if (i_en) begin
      if (i_start) begin
        r_a    <= i_a;
        r_b    <= i_b;
        r_acc  <= '0;
        r_step <= '0;
        r_busy <= 1'b1;
      end else if (r_busy) begin
        if (r_a[r_step]) r_acc <= r_acc + w_addend;
        r_step <= r_step + 3'd1;
        if (o_last) r_busy <= 1'b0;
      end
    end
  end
endmodule

// File: rtl/stock_buy_datapath.sv
// Buy-side order processor: cost = qty x price, then cash/ceiling checks and
// the updated holding/cash with an accept/reject code.
module stock_buy_datapath
  import market_pkg::*;
(
  input  logic        clock_50,
  input  logic        reset,
  stock_buy_if.slave  bus
);
  localparam logic [QTY_W:0] QTY_CEIL = (QTY_W+1)'(QTY_MAX);

  state_e             r_state, w_next;
  logic               w_hs;
  logic               w_mult_busy, w_mult_last;
  logic [COST_W-1:0]  w_cost;
  logic [QTY_W-1:0]   r_amt, r_qty;
  logic [CASH_W-1:0]  r_cash;
  logic               r_done;
  rej_e               r_code;
  logic [QTY_W-1:0]   r_qty_out;
  logic [CASH_W-1:0]  r_cash_out;
  logic [QTY_W:0]     w_qty_sum;
  logic [CASH_W-1:0]  w_cost_ext;
  logic               w_cash_short, w_qty_ovf;

  assign w_hs            = bus.enable && bus.req_valid && (r_state == ST_IDLE);
  assign bus.req_ready   = (r_state == ST_IDLE);
  assign bus.busy        = (r_state != ST_IDLE);
  assign bus.done        = r_done;
  assign bus.reject_code = r_code;
  assign bus.qty_out     = r_qty_out;
  assign bus.cash_out    = r_cash_out;

  seq_mult_8x12 u_mult (
    .clk       (clock_50),
    .rst       (reset),
    .i_en      (bus.enable),
    .i_start   (w_hs),
    .i_a       (bus.buy_amt),
    .i_b       (bus.stock_price),
    .o_busy    (w_mult_busy),
    .o_last    (w_mult_last),
    .o_product (w_cost)
  );

  always_ff @(posedge clock_50) begin
    if (reset)           r_state <= ST_IDLE;
    else if (bus.enable) r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (w_hs) w_next = ST_MULT;
      ST_MULT:  if (w_mult_busy && w_mult_last) w_next = ST_CHECK;
      ST_CHECK: w_next = ST_DONE;
      ST_DONE:  w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  // Cash shortfall takes priority over the holding ceiling.
  assign w_cost_ext   = CASH_W'(w_cost);
  assign w_qty_sum    = {1'b0, r_qty} + {1'b0, r_amt};
  assign w_cash_short = w_cost_ext > r_cash;
  assign w_qty_ovf    = w_qty_sum > QTY_CEIL;

  always_ff @(posedge clock_50) begin
    if (reset) begin
      r_amt      <= '0;
      r_qty      <= '0;
      r_cash     <= '0;
      r_done     <= 1'b0;
      r_code     <= REJ_OK;
      r_qty_out  <= '0;
      r_cash_out <= '0;
    end else if (bus.enable) begin
      r_done <= (r_state == ST_CHECK);
      if (w_hs) begin
        r_amt  <= bus.buy_amt;
        r_qty  <= bus.qty_init;
        r_cash <= bus.cash_init;
      end
      if (r_state == ST_CHECK) begin
        if (w_cash_short) begin
          r_code     <= REJ_CASH;
          r_qty_out  <= r_qty;
          r_cash_out <= r_cash;
        end else if (w_qty_ovf) begin
          r_code     <= REJ_QTY;
          r_qty_out  <= r_qty;
          r_cash_out <= r_cash;
        end else begin
          r_code     <= REJ_OK;
          r_qty_out  <= w_qty_sum[QTY_W-1:0];
          r_cash_out <= r_cash - w_cost_ext;
        end
      end
    end
  end
endmodule

// File: tb/tb_stock_buy_datapath.sv
// Scoreboard bench: driver pushes model results at each handshake, monitor
// pops and compares whenever done is presented.
module tb_stock_buy_datapath;
  import market_pkg::*;

  logic clock_50 = 1'b0;
  logic reset;
  always #10 clock_50 = ~clock_50;

  stock_buy_if bus();
  stock_buy_datapath dut (.clock_50(clock_50), .reset(reset), .bus(bus));

  typedef struct {
    int code;
    int qty;
    int cash;
    int cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int errors = 0;
  int checks = 0;
  int cyc = 0;

  always @(posedge clock_50) cyc <= cyc + 1;

  task automatic check(string name, longint act, longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: cost is plain integer product; cash shortfall beats holding ceiling.
  function automatic exp_t model(int amt, int price, int qty, int cash, int hs, int stall);
    exp_t m;
    longint cost = longint'(amt) * longint'(price);
    m.cyc = hs + 9 + stall;
    if (cost > cash) begin
      m.code = 1; m.qty = qty; m.cash = cash;
    end else if (qty + amt > 255) begin
      m.code = 2; m.qty = qty; m.cash = cash;
    end else begin
      m.code = 0; m.qty = qty + amt; m.cash = cash - int'(cost);
    end
    return m;
  endfunction

  always @(negedge clock_50) begin
    if (!reset && bus.done) begin
      if (sb.size() == 0) check("unexpected_done", 1, 0);
      else begin
        mon_e = sb.pop_front();
        check("reject_code", bus.reject_code, mon_e.code);
        check("qty_out", bus.qty_out, mon_e.qty);
        check("cash_out", bus.cash_out, mon_e.cash);
        check("done_cycle", cyc, mon_e.cyc);
      end
    end
  end

  task automatic scramble();
    bus.buy_amt     = 8'($urandom);
    bus.stock_price = 12'($urandom);
    bus.qty_init    = 8'($urandom);
    bus.cash_init   = 24'($urandom);
  endtask

  task automatic issue(int amt, int price, int qty, int cash, int stall, bit track);
    int t = 0;
    int hs;
    @(negedge clock_50);
    bus.req_valid   = 1'b1;
    bus.buy_amt     = 8'(amt);
    bus.stock_price = 12'(price);
    bus.qty_init    = 8'(qty);
    bus.cash_init   = 24'(cash);
    while (!bus.req_ready && t < 50) begin
      @(negedge clock_50);
      t++;
    end
    if (!bus.req_ready) begin
      check("ready_timeout", 0, 1);
      bus.req_valid = 1'b0;
      return;
    end
    hs = cyc + 1;
    if (track) sb.push_back(model(amt, price, qty, cash, hs, stall));
    @(negedge clock_50);
    bus.req_valid = 1'b0;
    scramble();
    if (stall > 0) begin
      repeat (2) @(negedge clock_50);
      bus.enable = 1'b0;
      repeat (stall) @(negedge clock_50);
      bus.enable = 1'b1;
    end
  endtask

  task automatic drain();
    int t = 0;
    while (sb.size() != 0 && t < 60) begin
      @(negedge clock_50);
      t++;
    end
    if (sb.size() != 0) begin
      check("done_timeout", sb.size(), 0);
      sb.delete();
    end
    @(negedge clock_50);
  endtask

  task automatic check_idle_zero(string tag);
    check({tag, "_ready"}, bus.req_ready, 1);
    check({tag, "_busy"}, bus.busy, 0);
    check({tag, "_done"}, bus.done, 0);
    check({tag, "_code"}, bus.reject_code, 0);
    check({tag, "_qty"}, bus.qty_out, 0);
    check({tag, "_cash"}, bus.cash_out, 0);
  endtask

  initial begin
    int amt, price, qty, cash, cost, sel, hs, last, ncap;
    reset = 1'b1;
    bus.enable = 1'b1;
    bus.req_valid = 1'b0;
    scramble();
    repeat (3) @(negedge clock_50);
    check_idle_zero("reset");
    reset = 1'b0;

    issue(10, 100, 20, 5000, 0, 1);      drain();
    issue(50, 4095, 0, 100000, 0, 1);    drain();
    issue(10, 100, 5, 1000, 0, 1);       drain();
    issue(10, 1, 250, 1000, 0, 1);       drain();
    issue(10, 1, 250, 5, 0, 1);          drain();
    issue(255, 4095, 0, 16777215, 0, 1); drain();
    issue(0, 1234, 77, 999, 0, 1);       drain();
    issue(10, 100, 20, 5000, 3, 1);      drain();

    // req_valid held high: one capture every 11 cycles
    @(negedge clock_50);
    bus.req_valid = 1'b1;
    bus.buy_amt = 8'd3; bus.stock_price = 12'd7; bus.qty_init = 8'd1; bus.cash_init = 24'd100;
    last = -1;
    ncap = 0;
    for (int i = 0; i < 44; i++) begin
      if (bus.req_ready) begin
        hs = cyc + 1;
        if (last >= 0) check("capture_gap", hs - last, 11);
        last = hs;
        ncap++;
        sb.push_back(model(3, 7, 1, 100, hs, 0));
      end
      @(negedge clock_50);
    end
    bus.req_valid = 1'b0;
    check("capture_count", ncap, 4);
    drain();

    // reset during the 4th multiply step discards the order
    issue(200, 3000, 9, 16000000, 0, 0);
    repeat (3) @(negedge clock_50);
    reset = 1'b1;
    @(negedge clock_50);
    check_idle_zero("midreset");
    reset = 1'b0;
    repeat (15) @(negedge clock_50);
    issue(7, 11, 2, 500, 0, 1);          drain();

    for (int n = 0; n < 25; n++) begin
      amt   = int'($urandom_range(0, 255));
      price = int'($urandom_range(0, 4095));
      qty   = int'($urandom_range(0, 255));
      cost  = amt * price;
      sel   = int'($urandom_range(0, 3));
      case (sel)
        0: cash = int'($urandom_range(0, 16777215));
        1: cash = cost;
        2: cash = (cost > 0) ? cost - 1 : 0;
        default: cash = cost + int'($urandom_range(0, 1000));
      endcase
      issue(amt, price, qty, cash, ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0, 1);
      drain();
    end

    check("scoreboard_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
